// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback slice: opcode constants,
// instruction layout and the decode helper that says whether rs1 is read.
package alu_pkg;

  localparam int REGISTER_WIDTH = 32;
  localparam int IDX_W          = 3;

  // ALU class select (opsel)
  localparam logic [2:0] SHIFT_REG   = 3'b000;
  localparam logic [2:0] ARITH_LOGIC = 3'b001;
  localparam logic [2:0] MEM_WRITE   = 3'b100;
  localparam logic [2:0] MEM_READ    = 3'b101;

  // ARITH_LOGIC operations
  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] HADD = 3'b001;
  localparam logic [2:0] SUB  = 3'b010;
  localparam logic [2:0] NOT  = 3'b011;
  localparam logic [2:0] AND  = 3'b100;
  localparam logic [2:0] OR   = 3'b101;
  localparam logic [2:0] XOR  = 3'b110;
  localparam logic [2:0] LHG  = 3'b111;

  // MEM_READ operations
  localparam logic [2:0] LOADBYTE      = 3'b000;
  localparam logic [2:0] LOADBYTEU     = 3'b001;
  localparam logic [2:0] LOADHALF      = 3'b010;
  localparam logic [2:0] LOADHALFU     = 3'b011;
  localparam logic [2:0] LOADWORD      = 3'b100;
  localparam logic [2:0] LOADWORDU     = 3'b101;
  localparam logic [2:0] LOADDOUBLE    = 3'b110;
  localparam logic [2:0] LOADDOUBLEU   = 3'b111;

  typedef struct packed {
    logic [2:0]  opsel;
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        imm_sel;
    logic [15:0] imm16;
  } instr_t;

  // Only two-operand arithmetic/logic ops read rs1; NOT and LHG are unary.
  function automatic logic uses_rs1(input logic [2:0] opsel, input logic [2:0] op);
    return (opsel == ARITH_LOGIC) &&
           ((op == ADD) || (op == HADD) || (op == SUB) ||
            (op == AND) || (op == OR)   || (op == XOR));
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports plus a debug read port,
// one synchronous write port, r0 hardwired to zero, synchronous clear.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [AW-1:0]             rd_addr1,
  output logic [REGISTER_WIDTH-1:0] rd_data1,
  input  logic [AW-1:0]             rd_addr2,
  output logic [REGISTER_WIDTH-1:0] rd_data2,
  input  logic [AW-1:0]             dbg_addr,
  output logic [REGISTER_WIDTH-1:0] dbg_data,
  input  logic                      we,
  input  logic [AW-1:0]             wr_addr,
  input  logic [REGISTER_WIDTH-1:0] wr_data
);

  logic [REGISTER_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/operand-fetch and writeback stage around the external ALU:
// S1 drives the ALU for one cycle, S2 writes the ALU result back.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [31:0]       aluin1,
  output logic [31:0]       aluin2,
  output logic [2:0]        aluoperation,
  output logic [2:0]        aluopselect,
  output logic              enable,
  input  logic [32:0]       aluout,
  output logic              wb_valid,
  output logic [2:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              carry_flag,
  output logic [CNT_W-1:0]  illegal_cnt,
  input  logic [2:0]        dbg_addr,
  output logic [31:0]       dbg_data
);

  // Handshake: a word transfers on a clock edge where instr_valid && instr_ready.
  // instr_ready is combinational from instr (hazard check); upstream must hold
  // instr stable while instr_valid && !instr_ready.

  instr_t d;
  assign d = instr_t'(instr);

  logic        legal, use1, use2, stall, accept, fwd1, fwd2;
  logic [31:0] rf1, rf2, op1, op2, imm_ext;

  logic        s1_valid, s1_arith;
  logic [2:0]  s1_rd;
  logic        s2_valid, s2_arith;
  logic [2:0]  s2_rd;

  always_comb begin
    legal   = (d.opsel == ARITH_LOGIC) || (d.opsel == MEM_READ);
    use1    = uses_rs1(d.opsel, d.op);
    use2    = !d.imm_sel;
    imm_ext = {{16{d.imm16[15]}}, d.imm16};
    // A source produced by the op now in S1 is not available yet: one bubble.
    stall   = legal && s1_valid && (s1_rd != 3'd0) &&
              ((use1 && (d.rs1 == s1_rd)) || (use2 && (d.rs2 == s1_rd)));
    fwd1    = s2_valid && (s2_rd != 3'd0) && (d.rs1 == s2_rd);
    fwd2    = s2_valid && (s2_rd != 3'd0) && (d.rs2 == s2_rd);
    op1     = use1 ? (fwd1 ? aluout[31:0] : rf1) : 32'd0;
    op2     = d.imm_sel ? imm_ext : (fwd2 ? aluout[31:0] : rf2);
  end

  assign instr_ready = !reset && !stall;
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_rd        <= '0;
      s1_arith     <= 1'b0;
      s2_valid     <= 1'b0;
      s2_rd        <= '0;
      s2_arith     <= 1'b0;
      aluin1       <= '0;
      aluin2       <= '0;
      aluoperation <= '0;
      aluopselect  <= '0;
      carry_flag   <= 1'b0;
      illegal_cnt  <= '0;
    end else begin
      s1_valid <= accept && legal;
      if (accept && legal) begin
        aluin1       <= op1;
        aluin2       <= op2;
        aluoperation <= d.op;
        aluopselect  <= d.opsel;
        s1_rd        <= d.rd;
        s1_arith     <= (d.opsel == ARITH_LOGIC);
      end
      s2_valid <= s1_valid;
      s2_rd    <= s1_rd;
      s2_arith <= s1_arith;
      if (s2_valid && s2_arith) carry_flag <= aluout[32];
      if (accept && !legal && (illegal_cnt != {CNT_W{1'b1}}))
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign enable   = s1_valid;
  assign wb_valid = s2_valid;
  assign wb_rd    = s2_rd;
  assign wb_data  = aluout[31:0];

  alu_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .rd_addr1 (d.rs1),
    .rd_data1 (rf1),
    .rd_addr2 (d.rs2),
    .rd_data2 (rf2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (s2_valid && (s2_rd != 3'd0)),
    .wr_addr  (s2_rd),
    .wr_data  (aluout[31:0])
  );

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural registered ALU model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] aluin1, aluin2;
  logic [2:0]  aluoperation, aluopselect;
  logic        enable;
  logic [32:0] aluout;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic        carry_flag;
  logic [7:0]  illegal_cnt;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_stage #(.NUM_REGS(8), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .aluin1(aluin1), .aluin2(aluin2), .aluoperation(aluoperation),
    .aluopselect(aluopselect), .enable(enable), .aluout(aluout), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .carry_flag(carry_flag), .illegal_cnt(illegal_cnt),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  // ALU model: MEM_READ reports carry 0 so a wrongful carry update is visible.
  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic [2:0] sel);
    logic [32:0] r;
    r = '0;
    if (sel == ARITH_LOGIC) begin
      case (op)
        ADD, HADD: r = {1'b0, a} + {1'b0, b};
        SUB:       r = {1'b0, a} - {1'b0, b};
        NOT:       r = {1'b0, ~b};
        AND:       r = {1'b0, a & b};
        OR:        r = {1'b0, a | b};
        XOR:       r = {1'b0, a ^ b};
        default:   r = {1'b0, b[15:0], 16'h0000};
      endcase
    end else if (sel == MEM_READ) begin
      if (op == LOADBYTE) r = {1'b0, {24{b[7]}}, b[7:0]};
      else                r = {1'b0, b};
    end
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset) aluout <= '0;
    else if (enable) aluout <= alu_f(aluin1, aluin2, aluoperation, aluopselect);
  end

  function automatic logic [31:0] mk(input logic [2:0] opsel, input logic [2:0] op,
                                     input logic [2:0] rd, input logic [2:0] rs1,
                                     input logic [2:0] rs2, input logic imm_sel,
                                     input logic [15:0] imm16);
    return {opsel, op, rd, rs1, rs2, imm_sel, imm16};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] x);
    instr_valid = 1'b1;
    instr = x;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    dbg_addr = '0;
    tick();
    tick();
    chk("rst_ready", instr_ready, 0);
    chk("rst_enable", enable, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_aluin1", aluin1, 0);
    chk("rst_illegal_cnt", illegal_cnt, 0);
    chk("rst_carry", carry_flag, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", instr_ready, 1);

    // ADDI r1 = r0 + 5
    send(mk(ARITH_LOGIC, ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005));
    chk("addi_enable", enable, 1);
    chk("addi_aluin1", aluin1, 32'd0);
    chk("addi_aluin2", aluin2, 32'd5);
    tick();
    chk("addi_enable_off", enable, 0);
    chk("addi_wb_valid", wb_valid, 1);
    chk("addi_wb_rd", wb_rd, 32'd1);
    chk("addi_wb_data", wb_data, 32'd5);
    tick();
    chk("addi_wb_off", wb_valid, 0);
    chk_reg("r1_is_5", 3'd1, 32'd5);

    // r2 = 7, then ADD r3 = r1 + r2
    send(mk(ARITH_LOGIC, ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0007));
    tick();
    tick();
    send(mk(ARITH_LOGIC, ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000));
    chk("add_aluin1", aluin1, 32'd5);
    chk("add_aluin2", aluin2, 32'd7);
    tick();
    chk("add_wb_data", wb_data, 32'd12);
    tick();
    chk_reg("r3_is_12", 3'd3, 32'd12);

    // Three independent back-to-back instructions
    instr_valid = 1'b1;
    instr = mk(ARITH_LOGIC, ADD, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0001);
    #1;
    chk("b2b_ready0", instr_ready, 1);
    tick();
    chk("b2b_en0", enable, 1);
    instr = mk(ARITH_LOGIC, ADD, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0002);
    #1;
    chk("b2b_ready1", instr_ready, 1);
    tick();
    chk("b2b_en1", enable, 1);
    chk("b2b_op1", aluin2, 32'd2);
    instr = mk(ARITH_LOGIC, ADD, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0003);
    #1;
    chk("b2b_ready2", instr_ready, 1);
    tick();
    chk("b2b_en2", enable, 1);
    chk("b2b_op2", aluin2, 32'd3);
    instr_valid = 1'b0;
    tick();
    chk("b2b_en_off", enable, 0);
    tick();
    tick();
    chk_reg("r6_is_2", 3'd6, 32'd2);

    // Dependent pair: r2 = -1, then ADD r4 = r2 + r2 (one stall, S2 forward)
    instr_valid = 1'b1;
    instr = mk(ARITH_LOGIC, ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFFFF);
    tick();
    instr = mk(ARITH_LOGIC, ADD, 3'd4, 3'd2, 3'd2, 1'b0, 16'h0000);
    #1;
    chk("dep_stall", instr_ready, 0);
    tick();
    chk("dep_bubble", enable, 0);
    chk("dep_ready_again", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    chk("dep_enable", enable, 1);
    chk("dep_fwd1", aluin1, 32'hFFFF_FFFF);
    chk("dep_fwd2", aluin2, 32'hFFFF_FFFF);
    tick();
    chk("dep_wb_rd", wb_rd, 32'd4);
    chk("dep_wb_data", wb_data, 32'hFFFF_FFFE);
    tick();
    chk("dep_carry", carry_flag, 1);
    chk_reg("r4_value", 3'd4, 32'hFFFF_FFFE);

    // Illegal opsel 100 then 000 back-to-back, then saturate the counter
    instr_valid = 1'b1;
    instr = mk(MEM_WRITE, 3'd0, 3'd1, 3'd1, 3'd1, 1'b0, 16'h0000);
    #1;
    chk("ill_ready", instr_ready, 1);
    tick();
    chk("ill_no_enable0", enable, 0);
    instr = mk(SHIFT_REG, 3'd0, 3'd1, 3'd1, 3'd1, 1'b0, 16'h0000);
    tick();
    instr_valid = 1'b0;
    chk("ill_no_enable1", enable, 0);
    chk("ill_cnt2", illegal_cnt, 32'd2);
    instr_valid = 1'b1;
    instr = mk(3'b111, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
    for (int i = 0; i < 298; i++) tick();
    instr_valid = 1'b0;
    chk("ill_cnt_sat", illegal_cnt, 32'd255);
    chk("ill_carry_kept", carry_flag, 1);

    // MEM_READ: r3 = 0x80 via LOADWORD imm, then LOADBYTE r5 from r3
    send(mk(MEM_READ, LOADWORD, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0080));
    tick();
    tick();
    send(mk(MEM_READ, LOADBYTE, 3'd5, 3'd1, 3'd3, 1'b0, 16'h0000));
    chk("lb_aluin1_zero", aluin1, 32'd0);
    chk("lb_aluin2", aluin2, 32'h0000_0080);
    chk("lb_opsel", aluopselect, 32'd5);
    tick();
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    tick();
    chk_reg("r5_value", 3'd5, 32'hFFFF_FF80);
    chk("lb_carry_kept", carry_flag, 1);

    // rd = 0 destination
    send(mk(ARITH_LOGIC, ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0009));
    tick();
    chk("r0_wb_valid", wb_valid, 1);
    chk("r0_wb_rd", wb_rd, 32'd0);
    chk("r0_wb_data", wb_data, 32'd9);
    tick();
    chk_reg("r0_stays_0", 3'd0, 32'd0);
    chk("r0_carry_cleared", carry_flag, 0);

    // Reset in cycle c1 of ADDI r6
    send(mk(ARITH_LOGIC, ADD, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0033));
    chk("mid_enable", enable, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", instr_ready, 0);
    tick();
    chk("mid_rst_enable", enable, 0);
    chk("mid_rst_wb", wb_valid, 0);
    reset = 1'b0;
    tick();
    chk("mid_after_wb", wb_valid, 0);
    chk_reg("mid_r6_zero", 3'd6, 32'd0);
    chk_reg("mid_r1_zero", 3'd1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue/operand-fetch and writeback stage wrapped around the ARITH_ALU datapath.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them.
- Reads an internal 8x32 register file and drives the ALU operand/control inputs with a one-cycle enable pulse.
- Captures the 33-bit ALU result one cycle later, writes it back to the register file, and updates a carry flag.
- Handles read-after-write hazards with one forwarding path and one stall.

Parameters:
NUM_REGS, 8, register file depth (r0 hardwired zero); index width = $clog2(NUM_REGS) = 3
CNT_W, 8, width of saturating illegal-instruction counter

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
instr_valid  in  1  upstream instruction valid
instr_ready  out  1  stage can accept instr this cycle
instr  in  32  {opsel[31:29], op[28:26], rd[25:23], rs1[22:20], rs2[19:17], imm_sel[16], imm16[15:0]}
aluin1  out  32  signed ALU operand 1
aluin2  out  32  signed ALU operand 2
aluoperation  out  3  ALU operation code
aluopselect  out  3  ALU class select
enable  out  1  ALU enable, one-cycle pulse per issued instr
aluout  in  33  ALU registered result {carry, data}
wb_valid  out  1  writeback occurring this cycle
wb_rd  out  3  writeback destination
wb_data  out  32  writeback data (= aluout[31:0])
carry_flag  out  1  last ARITH_LOGIC carry (aluout[32])
illegal_cnt  out  CNT_W  count of dropped illegal instrs, saturates at all-ones
dbg_addr  in  3  debug register read address
dbg_data  out  32  combinational regfile read (r0 reads 0; reflects committed state, no forwarding)

Behaviour:
- Reset (sync, active-high):
  - All regs and carry_flag cleared; illegal_cnt=0.
  - S1/S2 valid cleared; in-flight ops discarded, no writeback.
  - enable=0, aluin1/2=0, aluoperation=0, aluopselect=0, wb_valid=0.
  - instr_ready=0 during reset, 1 the cycle after.
- Legal opsel: ARITH_LOGIC (001), MEM_READ (101). Any other opsel is accepted and dropped: no enable, illegal_cnt+1 (saturating).
- Accept = instr_valid && instr_ready. instr_ready may depend on instr contents; upstream holds instr stable while valid && !ready.
- Pipeline: accept at edge E0 → S1 in cycle c1 (registered outputs: enable=1, operands, codes). ALU samples at E1 → S2 in c2 (aluout valid; wb_valid=1, wb_rd, wb_data=aluout[31:0]). Regfile write and carry update at E2.
- enable is 0 whenever S1 is empty.
- Operand sources:
  - aluin1 = R[rs1].
  - aluin2 = imm_sel ? sign-extended imm16 : R[rs2].
  - rs1 is used only for opsel=001 with op in {ADD,HADD,SUB,AND,OR,XOR}; otherwise aluin1=0.
  - aluin2 is always used.
- Hazards:
  - Stall (instr_ready=0) if S1 valid, S1.rd≠0, and a used source register equals S1.rd. The result is one bubble.
  - If a used source equals S2.rd (≠0, S2 valid), forward aluout[31:0] instead of the regfile value.
  - Forwarding priority: S2 forward over regfile. S1 match always stalls.
  - r0 is never forwarded or stalled on.
- Writeback:
  - rd=0 → wb_valid still pulses, but no regfile write.
  - carry_flag updated only for opsel=001; MEM_READ leaves it unchanged.
- Throughput: 1 instr/cycle when independent; dependent back-to-back costs exactly 1 cycle.
- No stall is caused by an illegal instr; it does not occupy S1/S2.

Decomposition:
- Shared package alu_pkg:
  - opsel/op constants (ADD..LHG, ARITH_LOGIC, MEM_READ, MEM_WRITE, SHIFT_REG, LOAD*).
  - REGISTER_WIDTH=32.
  - instr_t packed-struct typedef for the instruction fields.
  - A function uses_rs1(opsel, op).
- One sub-module: alu_regfile (NUM_REGS x 32, two combinational read ports plus debug port, one sync write port, r0=0, sync reset clear).

Test Plan:
- Reset then ADDI r1=r0+imm 0x0005 (imm_sel=1) → enable pulse 1 cycle after accept, aluin2=5; wb_valid 2 cycles after accept with wb_rd=1, wb_data=5; dbg_data(r1)=5 after.
- Independent stream: r1=5, r2=7 via immediates, then ADD r3=r1+r2 issued ≥2 cycles later → r3=12; 3 back-to-back independent instrs → instr_ready stays 1, three consecutive enable pulses.
- Dependent pair: ADDI r1=0x7FFF_FFFF path (LHG 0x7FFF then OR imm 0xFFFF is invalid due to sign-ext; use ADDI -1 into r2, then ADD r4=r2+r2) → instr_ready=0 exactly one cycle; second instr gets aluin1=aluin2=0xFFFFFFFF via S2 forward; r4=0xFFFFFFFE, carry_flag=1.
- Illegal opsel 100 and 000 accepted back-to-back → no enable, illegal_cnt=2; 300 illegals → illegal_cnt=255.
- MEM_READ LOADBYTE rd=5 rs2 holding 0x0000_0080 → r5=0xFFFF_FF80, carry_flag unchanged from prior value; rd=0 destination → wb_valid=1, r0 still 0.
- Reset asserted in cycle c1 of an ADD to r6 → no writeback, enable=0 next cycle, r6=0, instr_ready=0 during reset.
